// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: packs framed 8-bit pixels into 32-bit words and buffers them in a fall-through FIFO
module pixel_word_fifo #(
  parameter int ROWS       = 112,
  parameter int COLS       = 112,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startFrame,
  input  logic [7:0]            pixelin,
  input  logic                  pixelvalid,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  state_t r_state, w_state_n;
  logic [7:0] r_row, r_col;
  logic [1:0] r_idx;
  logic [23:0] r_pack;
  logic [31:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
  logic [DEPTH_LOG2:0] r_count;
  logic [31:0] r_rd_data, w_word;
  logic r_overflow, w_accept, w_last, w_push, w_pop, w_full, w_wr;
  assign w_accept   = r_state == CAPTURE && pixelvalid;
  assign w_last     = r_row == LAST_ROW && r_col == LAST_COL;
  assign w_push     = (w_accept && r_idx == 2'd3) || r_state == FLUSH;
  // Lanes not yet filled are already zero because the pack register clears after every word
  assign w_word     = r_state == FLUSH ? {8'd0, r_pack} : {pixelin, r_pack};
  assign w_pop      = rd_en && r_count != '0;
  assign w_full     = r_count == (DEPTH_LOG2 + 1)'(DEPTH);
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_rd_ptr_n = r_rd_ptr + DEPTH_LOG2'(w_pop);
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = startFrame ? CAPTURE : IDLE;
      CAPTURE: w_state_n = (w_accept && w_last) ? (r_idx == 2'd3 ? DONE : FLUSH) : CAPTURE;
      FLUSH:   w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_idx      <= '0;
      r_pack     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE && startFrame) begin
        r_row      <= '0;
        r_col      <= '0;
        r_idx      <= '0;
        r_pack     <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        r_idx  <= r_idx + 2'd1;
        r_pack <= r_idx == 2'd3 ? '0 : r_pack | (24'(pixelin) << {r_idx, 3'b000});
        r_col  <= r_col == LAST_COL ? '0 : r_col + 8'd1;
        if (r_col == LAST_COL) r_row <= r_row + 8'd1;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= r_count + (DEPTH_LOG2 + 1)'(w_wr) - (DEPTH_LOG2 + 1)'(w_pop);
      if (w_wr || w_pop) r_rd_data <= (w_wr && w_rd_ptr_n == r_wr_ptr) ? w_word : r_mem[w_rd_ptr_n];
    end
  end
  always_ff @(posedge clk) begin
    if (reset && w_wr) r_mem[r_wr_ptr] <= w_word;
  end
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_count != '0;
  assign fifo_count = r_count;
  assign busy       = r_state == CAPTURE || r_state == FLUSH;
  assign frame_done = r_state == DONE;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_pixel_word_fifo.sv
// tb_pixel_word_fifo: directed checks of packing, flush, overflow, boundary push+pop and mid-frame reset
module tb_pixel_word_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sf_a = 0, pv_a = 0, re_a = 0, sf_b = 0, pv_b = 0, re_b = 0, sf_c = 0, pv_c = 0, re_c = 0;
  logic [7:0] px_a = 0, px_b = 0, px_c = 0;
  logic [31:0] rd_a, rd_b, rd_c;
  logic rv_a, rv_b, rv_c, bz_a, bz_b, bz_c, fd_a, fd_b, fd_c, ov_a, ov_b, ov_c;
  logic [4:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pixel_word_fifo #(.ROWS(2), .COLS(4), .DEPTH_LOG2(4)) dut_a (
    .clk(clk), .reset(rst_n), .startFrame(sf_a), .pixelin(px_a), .pixelvalid(pv_a), .rd_en(re_a),
    .rd_data(rd_a), .rd_valid(rv_a), .fifo_count(cnt_a), .busy(bz_a), .frame_done(fd_a), .overflow(ov_a));
  pixel_word_fifo #(.ROWS(1), .COLS(6), .DEPTH_LOG2(4)) dut_b (
    .clk(clk), .reset(rst_n), .startFrame(sf_b), .pixelin(px_b), .pixelvalid(pv_b), .rd_en(re_b),
    .rd_data(rd_b), .rd_valid(rv_b), .fifo_count(cnt_b), .busy(bz_b), .frame_done(fd_b), .overflow(ov_b));
  pixel_word_fifo #(.ROWS(4), .COLS(8), .DEPTH_LOG2(2)) dut_c (
    .clk(clk), .reset(rst_n), .startFrame(sf_c), .pixelin(px_c), .pixelvalid(pv_c), .rd_en(re_c),
    .rd_data(rd_c), .rd_valid(rv_c), .fifo_count(cnt_c), .busy(bz_c), .frame_done(fd_c), .overflow(ov_c));

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      pv_a = ~pv_a; pv_b = ~pv_b; pv_c = ~pv_c;
      @(negedge clk);
    end
    pv_a = 0; pv_b = 0; pv_c = 0;
    tests++; if (rd_a !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected %h", rd_a, 32'h0); end
    tests++; if (rv_a !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", rv_a); end
    tests++; if (cnt_a !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
    tests++; if (bz_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bz_a); end
    tests++; if (fd_a !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", fd_a); end
    tests++; if (ov_c !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", ov_c); end
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      pv_a = 1; px_a = 8'(i + 1); @(negedge clk);
      pv_a = 0; @(negedge clk);
    end
    tests++; if (cnt_a !== 5'd0) begin fails++; $display("FAIL idle_ignores_pixels count: got %0d expected 0", cnt_a); end
    tests++; if (bz_a !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", bz_a); end
  endtask

  task automatic test_packing();
    logic [3:0] fdv, bzv;
    sf_a = 1; @(negedge clk); sf_a = 0;
    for (int i = 0; i < 8; i++) begin
      pv_a = 1; px_a = 8'(i + 1); @(negedge clk);
      if (i == 3) begin
        tests++; if (rv_a !== 1'b1 || cnt_a !== 5'd1) begin fails++; $display("FAIL pack_latency: got valid=%b count=%0d expected valid=1 count=1", rv_a, cnt_a); end
        tests++; if (rd_a !== 32'h04030201) begin fails++; $display("FAIL pack_first_head: got %h expected %h", rd_a, 32'h04030201); end
        tests++; if (bz_a !== 1'b1) begin fails++; $display("FAIL pack_busy_capture: got %b expected 1", bz_a); end
      end
    end
    pv_a = 0;
    for (int k = 0; k < 4; k++) begin fdv[k] = fd_a; bzv[k] = bz_a; @(negedge clk); end
    tests++; if (fdv !== 4'b0001) begin fails++; $display("FAIL pack_frame_done_pulse: got %b expected %b", fdv, 4'b0001); end
    tests++; if (bzv !== 4'b0000) begin fails++; $display("FAIL pack_busy_after: got %b expected %b", bzv, 4'b0000); end
    tests++; if (rd_a !== 32'h04030201 || cnt_a !== 5'd2) begin fails++; $display("FAIL pack_words: got %h count=%0d expected %h count=2", rd_a, cnt_a, 32'h04030201); end
    re_a = 1; @(negedge clk); re_a = 0;
    tests++; if (rd_a !== 32'h08070605 || cnt_a !== 5'd1) begin fails++; $display("FAIL pack_pop: got %h count=%0d expected %h count=1", rd_a, cnt_a, 32'h08070605); end
    re_a = 1; @(negedge clk); re_a = 0;
    tests++; if (cnt_a !== 5'd0 || rv_a !== 1'b0) begin fails++; $display("FAIL pack_drain: got count=%0d valid=%b expected 0 0", cnt_a, rv_a); end
    re_a = 1; @(negedge clk); re_a = 0;
    tests++; if (cnt_a !== 5'd0) begin fails++; $display("FAIL pop_when_empty: got count=%0d expected 0", cnt_a); end
  endtask

  task automatic test_flush();
    logic [3:0] fdv, bzv;
    sf_b = 1; @(negedge clk); sf_b = 0;
    for (int i = 0; i < 6; i++) begin pv_b = 1; px_b = 8'(8'hA0 + i); @(negedge clk); end
    pv_b = 0;
    for (int k = 0; k < 4; k++) begin fdv[k] = fd_b; bzv[k] = bz_b; @(negedge clk); end
    tests++; if (fdv !== 4'b0010) begin fails++; $display("FAIL flush_frame_done_timing: got %b expected %b", fdv, 4'b0010); end
    tests++; if (bzv !== 4'b0001) begin fails++; $display("FAIL flush_single_cycle: got %b expected %b", bzv, 4'b0001); end
    tests++; if (rd_b !== 32'hA3A2A1A0 || cnt_b !== 5'd2) begin fails++; $display("FAIL flush_words: got %h count=%0d expected %h count=2", rd_b, cnt_b, 32'hA3A2A1A0); end
    re_b = 1; @(negedge clk); re_b = 0;
    tests++; if (rd_b !== 32'h0000A5A4) begin fails++; $display("FAIL flush_partial_word: got %h expected %h", rd_b, 32'h0000A5A4); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    sf_c = 1; @(negedge clk); sf_c = 0;
    for (int i = 0; i < 32; i++) begin
      pv_c = 1; px_c = 8'(i + 1); @(negedge clk);
      if (i == 15) begin
        tests++; if (cnt_c !== 3'd4 || ov_c !== 1'b0) begin fails++; $display("FAIL ovf_full_no_flag: got count=%0d ovf=%b expected 4 0", cnt_c, ov_c); end
      end
      if (i == 19) begin
        tests++; if (ov_c !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", ov_c); end
      end
    end
    pv_c = 0;
    repeat (3) @(negedge clk);
    tests++; if (cnt_c !== 3'd4 || ov_c !== 1'b1) begin fails++; $display("FAIL ovf_saturate: got count=%0d ovf=%b expected 4 1", cnt_c, ov_c); end
    for (int k = 0; k < 4; k++) begin
      exp = {8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
      tests++; if (rd_c !== exp) begin fails++; $display("FAIL ovf_word%0d: got %h expected %h", k, rd_c, exp); end
      re_c = 1; @(negedge clk); re_c = 0;
    end
    tests++; if (cnt_c !== 3'd0) begin fails++; $display("FAIL ovf_drain: got count=%0d expected 0", cnt_c); end
    sf_c = 1; @(negedge clk); sf_c = 0;
    tests++; if (ov_c !== 1'b0 || bz_c !== 1'b1) begin fails++; $display("FAIL ovf_clear_on_start: got ovf=%b busy=%b expected 0 1", ov_c, bz_c); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      pv_c = 1; px_c = 8'(8'h41 + i); re_c = (i == 19); @(negedge clk); re_c = 0;
      if (i == 15) begin
        tests++; if (cnt_c !== 3'd4 || rd_c !== 32'h44434241) begin fails++; $display("FAIL b2b_prefill: got %h count=%0d expected %h count=4", rd_c, cnt_c, 32'h44434241); end
      end
    end
    pv_c = 0;
    tests++; if (cnt_c !== 3'd4 || ov_c !== 1'b0) begin fails++; $display("FAIL b2b_full_push_pop: got count=%0d ovf=%b expected 4 0", cnt_c, ov_c); end
    tests++; if (rd_c !== 32'h48474645) begin fails++; $display("FAIL b2b_head_advance: got %h expected %h", rd_c, 32'h48474645); end
  endtask

  task automatic test_midframe();
    sf_a = 1; @(negedge clk); sf_a = 0;
    for (int i = 0; i < 4; i++) begin
      pv_a = 1; px_a = 8'(8'h11 + i); sf_a = (i == 2); @(negedge clk);
    end
    sf_a = 0;
    tests++; if (cnt_a !== 5'd1 || rd_a !== 32'h14131211) begin fails++; $display("FAIL ignore_start_in_capture: got %h count=%0d expected %h count=1", rd_a, cnt_a, 32'h14131211); end
    px_a = 8'h15; @(negedge clk);
    pv_a = 0; rst_n = 0; @(negedge clk);
    tests++; if (bz_a !== 1'b0 || cnt_a !== 5'd0 || rv_a !== 1'b0) begin fails++; $display("FAIL midframe_reset: got busy=%b count=%0d valid=%b expected 0 0 0", bz_a, cnt_a, rv_a); end
    tests++; if (rd_a !== 32'h0) begin fails++; $display("FAIL midframe_reset_rd_data: got %h expected %h", rd_a, 32'h0); end
    rst_n = 1; sf_a = 1; @(negedge clk); sf_a = 0;
    for (int i = 0; i < 4; i++) begin pv_a = 1; px_a = 8'(8'h21 + i); @(negedge clk); end
    pv_a = 0;
    tests++; if (rd_a !== 32'h24232221 || cnt_a !== 5'd1) begin fails++; $display("FAIL restart_lane0: got %h count=%0d expected %h count=1", rd_a, cnt_a, 32'h24232221); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_packing();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
